// File: rtl/i2s_pkg.sv
// Shared types and default geometry for the I2S receiver.
// Holds the capture FSM state encoding and the default slot layout.
package i2s_pkg;

   typedef enum logic [1:0] {
      ALIGN = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2,
      SKIP  = 2'd3
   } state_e;

   localparam int DEF_DATA_BITS = 24;
   localparam int DEF_SLOT_BITS = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings one asynchronous input into the clk_i domain.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d_i;
         sync_reg <= meta_reg;
      end
   end

   assign q_o = sync_reg;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCK/WS/SD on clk_i, captures one channel slot and
// presents it as a sign-extended sample behind a valid/ready handshake.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int SLOT_BITS = DEF_SLOT_BITS,
   parameter bit CHANNEL   = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    sck_i,
   input  logic                    ws_i,
   input  logic                    sd_i,
   output logic signed [WIDTH-1:0] sample_o,
   output logic                    sample_valid_o,
   input  logic                    sample_ready_i,
   output logic                    overrun_o,
   output logic                    frame_err_o
);

   localparam int              CNT_W    = $clog2(SLOT_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   logic [2:0] async_in;
   logic [2:0] sync_out;
   logic       sck_sync;
   logic       ws_sync;
   logic       sd_sync;

   assign async_in = {sck_i, ws_i, sd_i};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_2ff u_sync (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (async_in[gi]),
         .q_o    (sync_out[gi])
      );
   end

   assign sck_sync = sync_out[2];
   assign ws_sync  = sync_out[1];
   assign sd_sync  = sync_out[0];

   state_e                    state_reg;
   state_e                    state_next;
   logic                      sck_prev_reg;
   logic                      ws_last_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [DATA_BITS-2:0]      shift_reg;
   logic signed [WIDTH-1:0]   sample_reg;
   logic                      valid_reg;
   logic                      overrun_reg;
   logic                      frame_err_reg;

   logic                      strobe;
   logic                      ws_edge;
   logic                      ws_to_ch;
   logic                      cnt_clr;
   logic                      shift_en;
   logic                      load;
   logic                      ferr_set;
   logic [DATA_BITS-1:0]      new_word;
   logic signed [DATA_BITS-1:0] word_s;
   logic signed [WIDTH-1:0]   sample_ext;

   // WS is only meaningful at SCK rising edges, so its history advances on the strobe.
   assign strobe   = sck_sync & ~sck_prev_reg;
   assign ws_edge  = strobe & (ws_sync != ws_last_reg);
   assign ws_to_ch = ws_edge & (ws_sync == CHANNEL);

   // The final bit is merged combinationally so the load happens on its own strobe.
   assign new_word   = {shift_reg, sd_sync};
   assign word_s     = new_word;
   assign sample_ext = WIDTH'(word_s);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ALIGN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ALIGN: if (ws_to_ch) state_next = DELAY;
         // The bit seen with the WS edge belongs to the previous word; nothing to wait for.
         DELAY: state_next = SHIFT;
         SHIFT: begin
            if (ws_edge) begin
               state_next = ALIGN;
            end else if (strobe && cnt_reg == LAST_BIT) begin
               state_next = SKIP;
            end
         end
         SKIP:  if (ws_to_ch) state_next = DELAY;
         default: state_next = ALIGN;
      endcase
   end

   always_comb begin
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      load     = 1'b0;
      ferr_set = 1'b0;
      case (state_reg)
         DELAY: cnt_clr = 1'b1;
         SHIFT: begin
            ferr_set = ws_edge;
            shift_en = strobe & ~ws_edge;
            load     = strobe & ~ws_edge & (cnt_reg == LAST_BIT);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_prev_reg <= 1'b0;
         ws_last_reg  <= 1'b0;
         cnt_reg      <= '0;
         shift_reg    <= '0;
      end else begin
         sck_prev_reg <= sck_sync;
         if (strobe) begin
            ws_last_reg <= ws_sync;
         end
         if (cnt_clr) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
         end else if (shift_en) begin
            cnt_reg   <= cnt_reg + 1'b1;
            shift_reg <= new_word[DATA_BITS-2:0];
         end
      end
   end

   // An unaccepted sample wins over a newly completed one; the new one is reported as overrun.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_reg    <= '0;
         valid_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (load && (!valid_reg || sample_ready_i)) begin
            sample_reg <= sample_ext;
            valid_reg  <= 1'b1;
         end else if (valid_reg && sample_ready_i) begin
            valid_reg <= 1'b0;
         end
         overrun_reg   <= load & valid_reg & ~sample_ready_i;
         frame_err_reg <= ferr_set;
      end
   end

   assign sample_o       = sample_reg;
   assign sample_valid_o = valid_reg;
   assign overrun_o      = overrun_reg;
   assign frame_err_o    = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives standard I2S frames at SCK = clk/4 and checks
// captured samples, handshake behaviour, error pulses and reset.
module tb_i2s_rx;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               sck_i;
   logic               ws_i;
   logic               sd_i;
   logic signed [31:0] sample_o;
   logic               sample_valid_o;
   logic               sample_ready_i;
   logic               overrun_o;
   logic               frame_err_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] acc_q[$];
   logic [31:0] exp_q[$];
   int          ovr_cnt;
   int          ferr_cnt;
   int          valid_cycles;
   int          stab_err;
   logic        prev_hold;
   logic [31:0] prev_sample;

   always #5 clk_i = ~clk_i;

   i2s_rx #(
      .WIDTH     (32),
      .DATA_BITS (24),
      .SLOT_BITS (32),
      .CHANNEL   (1'b0)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .sck_i          (sck_i),
      .ws_i           (ws_i),
      .sd_i           (sd_i),
      .sample_o       (sample_o),
      .sample_valid_o (sample_valid_o),
      .sample_ready_i (sample_ready_i),
      .overrun_o      (overrun_o),
      .frame_err_o    (frame_err_o)
   );

   // Observe outputs on the falling edge, away from the active edge.
   always @(negedge clk_i) begin
      if (sample_valid_o && sample_ready_i) acc_q.push_back(sample_o);
      if (overrun_o) ovr_cnt++;
      if (frame_err_o) ferr_cnt++;
      if (sample_valid_o) valid_cycles++;
      if (prev_hold && sample_o !== prev_sample) stab_err++;
      prev_hold   = sample_valid_o && !sample_ready_i;
      prev_sample = sample_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      acc_q.delete();
      ovr_cnt      = 0;
      ferr_cnt     = 0;
      valid_cycles = 0;
      stab_err     = 0;
   endtask

   // One SCK period: data/WS change on the falling edge, receiver samples on the rise.
   task automatic sck_bit(input logic w, input logic d);
      sck_i = 1'b0;
      ws_i  = w;
      sd_i  = d;
      repeat (2) @(posedge clk_i);
      #2;
      sck_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #2;
   endtask

   // Frame periods 0..63: 0..31 left (WS low), 32..63 right; MSB one period after the WS edge.
   // Unused periods carry 1s so discarded bits are visible if wrongly captured.
   task automatic send_periods(input logic [23:0] l, input logic [23:0] r,
                               input int lo, input int hi, input int flip_at);
      logic w;
      logic d;
      for (int p = lo; p <= hi; p++) begin
         w = (p >= 32);
         if (flip_at >= 0 && p >= flip_at && p < 32) w = 1'b1;
         if (p >= 1 && p <= 24)       d = l[24-p];
         else if (p >= 33 && p <= 56) d = r[56-p];
         else                         d = 1'b1;
         sck_bit(w, d);
      end
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_periods(l, r, 0, 63, -1);
   endtask

   function automatic logic [31:0] sext24(input logic [23:0] v);
      return {{8{v[23]}}, v};
   endfunction

   initial begin
      logic [23:0] l;
      logic [23:0] r;
      logic [31:0] obs;

      rst_ni         = 1'b0;
      sck_i          = 1'b0;
      ws_i           = 1'b1;
      sd_i           = 1'b0;
      sample_ready_i = 1'b1;
      prev_hold      = 1'b0;
      prev_sample    = '0;
      clear_mon();
      repeat (5) @(posedge clk_i);
      #2;
      check("reset_sample", sample_o, 32'h0);
      check("reset_valid", {31'b0, sample_valid_o}, 32'h0);
      check("reset_overrun", {31'b0, overrun_o}, 32'h0);
      check("reset_frame_err", {31'b0, frame_err_o}, 32'h0);
      rst_ni = 1'b1;
      send_periods(24'h0, 24'h0, 32, 63, -1);
      $display("reset and idle right slot done");

      // Negative full-scale-ish sample, ready high.
      clear_mon();
      send_frame(24'h800001, 24'h000000);
      check("neg_count", acc_q.size(), 1);
      obs = (acc_q.size() > 0) ? acc_q[0] : 'x;
      check("neg_value", obs, 32'hFF800001);
      check("neg_valid_cycles", valid_cycles, 1);
      check("neg_overrun", ovr_cnt, 0);
      check("neg_frame_err", ferr_cnt, 0);
      $display("frame L=800001 -> %h", obs);

      // Only the left slot is captured.
      clear_mon();
      send_frame(24'h7FFFFF, 24'h123456);
      check("left_only_count", acc_q.size(), 1);
      obs = (acc_q.size() > 0) ? acc_q[0] : 'x;
      check("left_only_value", obs, 32'h007FFFFF);
      $display("frame L=7FFFFF R=123456 -> %h", obs);

      // Backpressure across two frames: the first sample is held, the second overruns.
      clear_mon();
      sample_ready_i = 1'b0;
      send_frame(24'h000010, 24'hAAAAAA);
      send_frame(24'h000020, 24'h555555);
      check("hold_sample", sample_o, 32'h00000010);
      check("hold_valid", {31'b0, sample_valid_o}, 32'h1);
      check("hold_overrun", ovr_cnt, 1);
      check("hold_stable", stab_err, 0);
      sample_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #2;
      check("hold_drain_count", acc_q.size(), 1);
      obs = (acc_q.size() > 0) ? acc_q[0] : 'x;
      check("hold_drain_value", obs, 32'h00000010);
      check("hold_valid_fall", {31'b0, sample_valid_o}, 32'h0);
      $display("backpressure frames 10,20 -> drained %h, overruns %0d", obs, ovr_cnt);

      // WS returns high after 10 data bits.
      clear_mon();
      send_periods(24'h3C3C3C, 24'h0, 0, 63, 11);
      check("ferr_pulse", ferr_cnt, 1);
      check("ferr_no_sample", acc_q.size(), 0);
      send_frame(24'h000005, 24'h0);
      check("ferr_recover_count", acc_q.size(), 1);
      obs = (acc_q.size() > 0) ? acc_q[0] : 'x;
      check("ferr_recover_value", obs, 32'h00000005);
      check("ferr_total", ferr_cnt, 1);
      $display("short slot then L=000005 -> %h, frame errors %0d", obs, ferr_cnt);

      // Reset in the middle of SHIFT, released while still inside the left slot.
      clear_mon();
      send_periods(24'h555555, 24'h0, 0, 12, -1);
      rst_ni = 1'b0;
      #1;
      check("midrst_sample", sample_o, 32'h0);
      check("midrst_valid", {31'b0, sample_valid_o}, 32'h0);
      check("midrst_overrun", {31'b0, overrun_o}, 32'h0);
      check("midrst_frame_err", {31'b0, frame_err_o}, 32'h0);
      send_periods(24'h555555, 24'h0, 13, 19, -1);
      rst_ni = 1'b1;
      send_periods(24'h555555, 24'h0, 20, 63, -1);
      send_frame(24'hABCDEF, 24'h0);
      check("midrst_count", acc_q.size(), 1);
      obs = (acc_q.size() > 0) ? acc_q[0] : 'x;
      check("midrst_value", obs, 32'hFFABCDEF);
      $display("reset mid-slot then L=ABCDEF -> %h", obs);

      // 100 random frames at SCK = clk/4 with ready held high.
      clear_mon();
      exp_q.delete();
      for (int f = 0; f < 100; f++) begin
         l = 24'($urandom);
         r = 24'($urandom);
         exp_q.push_back(sext24(l));
         send_frame(l, r);
      end
      check("rand_count", acc_q.size(), 100);
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < acc_q.size()) ? acc_q[i] : 'x;
         check($sformatf("rand_%0d", i), obs, exp_q[i]);
         $display("random frame %0d -> %h (want %h)", i, obs, exp_q[i]);
      end
      check("rand_overrun", ovr_cnt, 0);
      check("rand_frame_err", ferr_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
